// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and constants for the UART receiver: the
//                receiver state encoding, the legal oversampling range,
//                the parity-type codes and the helpers built on them.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int   PRESCALE_MIN = 8;
    localparam int   PRESCALE_MAX = 32;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Out-of-range prescale values are pulled into the legal window so the
    // bit timing always leaves room for the three sample points and a wrap.
    function automatic logic [5:0] clamp_prescale(input logic [5:0] p);
        if (p < 6'(PRESCALE_MIN)) return 6'(PRESCALE_MIN);
        if (p > 6'(PRESCALE_MAX)) return 6'(PRESCALE_MAX);
        return p;
    endfunction

    // Expected parity bit given the XOR-reduction of the data word.
    function automatic logic expected_parity(input logic data_xor, input logic typ);
        if (typ == EVEN)     return data_xor;
        else if (typ == ODD) return ~data_xor;
        else                 return data_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_data_sampler
//  Description : Three-point mid-bit sampler with 2-of-3 majority vote.
//                Samples RX_IN at edge_cnt = P/2-1, P/2 and P/2+1; the voted
//                bit is registered and valid from edge_cnt = P/2+2, where
//                sample_done pulses for one cycle.
//  Ports       : CLK, RST (async, active-low), RX_IN serial line,
//                edge_cnt position inside the bit, Prescale cycles per bit,
//                sampled_bit voted bit, sample_done one-cycle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_data_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] Prescale,
    output logic       sampled_bit,
    output logic       sample_done
);

    logic [5:0] w_half;
    logic [5:0] w_pt0;
    logic [5:0] w_pt2;
    logic       r_s0;
    logic       r_s1;

    assign w_half = {1'b0, Prescale[5:1]};
    assign w_pt0  = w_half - 6'd1;
    assign w_pt2  = w_half + 6'd1;

    // The third sample is voted directly from the live line, so the result
    // lands one cycle after the last sample point.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            sampled_bit <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (edge_cnt == w_pt0)  r_s0 <= RX_IN;
            if (edge_cnt == w_half) r_s1 <= RX_IN;
            if (edge_cnt == w_pt2) begin
                sampled_bit <= (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
                sample_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Frame = start(0), DATA_WIDTH
//                data bits LSB-first, optional even/odd parity, one stop bit.
//                Frame parameters are latched at start detection. Results are
//                registered one cycle after the stop-bit wrap.
//  Ports       : CLK oversampling clock, RST async active-low reset,
//                RX_IN serial line, Prescale cycles per bit, PAR_EN/PAR_TYP
//                parity control, P_DATA last good word, data_valid/par_err/
//                stp_err one-cycle result pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int                  c_bcw      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_bcw-1:0]    c_last_bit = c_bcw'(DATA_WIDTH - 1);

    rx_state_t               r_state;
    logic [5:0]              r_edge_cnt;
    logic [c_bcw-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [5:0]              r_prescale;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_fail;

    logic                    w_sampled_bit;
    logic                    w_sample_done;
    logic                    w_wrap;

    assign w_wrap = (r_edge_cnt == (r_prescale - 6'd1));

    rx_data_sampler u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .edge_cnt    (r_edge_cnt),
        .Prescale    (r_prescale),
        .sampled_bit (w_sampled_bit),
        .sample_done (w_sample_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_prescale <= 6'(PRESCALE_MIN);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (r_state != IDLE)
                r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;

            case (r_state)
                IDLE: begin
                    r_edge_cnt <= 6'd0;
                    if (!RX_IN) begin
                        r_state    <= START;
                        r_prescale <= clamp_prescale(Prescale);
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_fail <= 1'b0;
                    end
                end

                START: begin
                    // A start bit that votes high was a glitch.
                    if (w_wrap) r_state <= w_sampled_bit ? IDLE : DATA;
                end

                DATA: begin
                    if (w_sample_done)
                        r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (w_sample_done)
                        r_par_fail <= (w_sampled_bit != expected_parity(^r_shift, r_par_typ));
                    if (w_wrap) r_state <= STOP;
                end

                STOP: begin
                    if (w_wrap) begin
                        if (!r_par_fail && w_sampled_bit) begin
                            P_DATA     <= r_shift;
                            data_valid <= 1'b1;
                        end
                        par_err <= r_par_fail;
                        stp_err <= ~w_sampled_bit;
                        // A low line here is the next start bit already.
                        if (!RX_IN) begin
                            r_state    <= START;
                            r_prescale <= clamp_prescale(Prescale);
                            r_par_en   <= PAR_EN;
                            r_par_typ  <= PAR_TYP;
                            r_par_fail <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_edge_cnt <= 6'd0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are serialised at the
//                bit level; a frame-level model predicts the result pulse,
//                its cycle and the held P_DATA value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    always #5 CLK = ~CLK;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    typedef struct packed {
        logic        v;
        logic        pe;
        logic        se;
        logic [7:0]  d;
        logic [15:0] cyc;
    } ev_t;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] model_pdata  = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK)
        if (RST && (data_valid || par_err || stp_err))
            got_q.push_back({data_valid, par_err, stp_err, P_DATA, cyc[15:0]});

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic good_parity(input logic [7:0] d, input logic typ);
        return (^d) ^ typ;
    endfunction

    // Sends one frame and records what the receiver should report for it.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic pbit, input logic stop_val,
                              input logic scramble);
        logic perr, serr, v;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        drive_bit(1'b0, p);
        if (scramble) begin
            Prescale = 6'(8 + 2 * $urandom_range(0, 12));
            PAR_EN   = ~pen;
            PAR_TYP  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop_val, p);
        perr = pen && (pbit != good_parity(d, ptyp));
        serr = !stop_val;
        v    = !perr && !serr;
        if (v) model_pdata = d;
        exp_q.push_back({v, perr, serr, model_pdata, 16'(cyc + 1)});
    endtask

    task automatic check_results(input string tag);
        ev_t e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            assert (got_q.size() != 0) else begin
                tests_failed++;
                $error("FAIL %s missing pulse: got none, expected v/pe/se/d/cyc=%b%b%b/%h/%0d",
                       tag, e.v, e.pe, e.se, e.d, e.cyc);
            end
            if (got_q.size() != 0) begin
                g = got_q.pop_front();
                tests_run++;
                assert (g === e) else begin
                    tests_failed++;
                    $error("FAIL %s pulse: got v/pe/se/d/cyc=%b%b%b/%h/%0d expected %b%b%b/%h/%0d",
                           tag, g.v, g.pe, g.se, g.d, g.cyc, e.v, e.pe, e.se, e.d, e.cyc);
                end
            end
        end
        tests_run++;
        assert (got_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL %s extra pulses: got %0d, expected 0", tag, got_q.size());
        end
        got_q.delete();
        tests_run++;
        assert (P_DATA === model_pdata) else begin
            tests_failed++;
            $error("FAIL %s P_DATA hold: got %h expected %h", tag, P_DATA, model_pdata);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        tests_run++;
        assert ({P_DATA, data_valid, par_err, stp_err} === 11'd0) else begin
            tests_failed++;
            $error("FAIL %s outputs: got P_DATA=%h dv=%b pe=%b se=%b expected all 0",
                   tag, P_DATA, data_valid, par_err, stp_err);
        end
    endtask

    initial begin
        logic [7:0] d;
        int         p;
        logic       pen, ptyp, pbit, stp;

        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(4);

        // Basic frame, no parity
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_results("p8_a5");

        // Even parity: good, then flipped parity bit
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_results("p16_even_ok");
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        check_results("p16_even_bad");

        // Odd parity with a broken stop bit
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_results("p32_stop_err");

        // Start glitch followed by a real frame
        Prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        idle(40);
        check_results("glitch");
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_results("after_glitch");

        // Back-to-back frames with no idle gap
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_results("back_to_back");

        // Reset in the middle of the data bits of 0xFF
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        #3;
        RST = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_pdata = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(200);
        check_results("after_reset_quiet");
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_results("after_reset_81");

        // Random frames; frame settings are disturbed after start detection
        for (int k = 0; k < 14; k++) begin
            d    = 8'($urandom);
            p    = 8 + 2 * $urandom_range(0, 12);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            pbit = good_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 3) != 0);
            send_frame(d, p, pen, ptyp, pbit, stp, 1'b1);
            idle(4 + $urandom_range(0, 4));
            check_results("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data bits.
REQ-002 SHALL have port CLK  input  1  oversampling clock (Prescale x bit rate).
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; frame = start(0), data LSB-first, optional parity, stop(1).
REQ-005 SHALL have port Prescale  input  6  CLK cycles per bit; legal values are even, 8..32.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last correctly received byte.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse at frame end on parity mismatch.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse at frame end when the stop bit is sampled as 0.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL maintain edge_cnt (0..Prescale-1), which increments every cycle outside IDLE and wraps to 0 at Prescale-1; each wrap ends one bit period.
REQ-014 SHALL maintain bit_cnt (0..DATA_WIDTH-1) in DATA, advancing on each edge_cnt wrap.
REQ-015 SHALL sample RX_IN at edge_cnt = P/2-1, P/2 and P/2+1, and SHALL take the sampled bit as the 2-of-3 majority, valid from edge_cnt = P/2+2.
REQ-016 In IDLE, SHALL go to START on the next cycle when RX_IN = 0, with edge_cnt = 0, latching Prescale, PAR_EN and PAR_TYP for the whole frame.
REQ-017 In START, at edge_cnt wrap: a sampled bit of 0 -> DATA; a sampled bit of 1 -> IDLE (glitch), with no output pulse.
REQ-018 In DATA, SHALL shift each sampled bit into an internal shift register LSB-first; at the wrap with bit_cnt = DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
REQ-019 In PARITY, SHALL compute the expected bit as XOR(data) for even parity or ~XOR(data) for odd parity, record a mismatch, and go to STOP at wrap.
REQ-020 In STOP, at wrap (the frame-end cycle), SHALL register the results for the following cycle:
- no error: P_DATA <= shift register, data_valid = 1;
- parity mismatch: par_err = 1;
- stop bit = 0: stp_err = 1;
- both errors may pulse together;
- on any error, data_valid = 0 and P_DATA holds its previous value.
REQ-021 At STOP wrap, SHALL go directly to START (edge_cnt = 0, with a new parameter latch) if RX_IN = 0, else to IDLE, so back-to-back frames lose no bit time.
REQ-022 Output latency SHALL be exactly one CLK after the frame-end cycle, and all outputs SHALL be registered.
REQ-023 Changes to Prescale, PAR_EN or PAR_TYP mid-frame SHALL have no effect until the next start detection.
REQ-024 Illegal Prescale values SHALL give unspecified data but SHALL NOT lock the FSM; an unreachable state encoding SHALL go to IDLE.

Reset
REQ-025 RST low SHALL immediately force IDLE, edge_cnt = 0, bit_cnt = 0, shift register = 0, P_DATA = 0, data_valid = 0, par_err = 0 and stp_err = 0, including mid-frame.
REQ-026 After RST release, SHALL require a fresh falling edge (RX_IN = 0 seen in IDLE) before receiving; a partial frame cut by reset SHALL produce no pulse.

Structure
REQ-027 Package uart_rx_pkg SHALL hold the state enum type, PRESCALE_MIN = 8, PRESCALE_MAX = 32 and the parity-type constants (EVEN = 0, ODD = 1).
REQ-028 The three-point sampling and majority vote SHALL live in a single sub-module rx_data_sampler (inputs CLK, RST, RX_IN, edge_cnt, Prescale; outputs sampled_bit, sample_done); all other logic SHALL stay in uart_rx.

Verification
REQ-029 Prescale = 8, PAR_EN = 0, byte 0xA5 sent -> data_valid pulses once, P_DATA = 0xA5, no error pulse.
REQ-030 Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit 0 -> P_DATA = 0x3C; the same byte with parity bit 1 -> par_err pulses, data_valid = 0, P_DATA stays 0x3C.
REQ-031 Prescale = 32, PAR_TYP = 1, byte 0x01 with stop bit driven 0 -> stp_err pulses, data_valid = 0.
REQ-032 RX_IN low for 2 cycles then high (Prescale = 16) -> FSM returns to IDLE, no output pulse; a following valid frame 0x5A is received correctly.
REQ-033 Frames 0x11, 0x22, 0x33 back-to-back with a single stop bit each at Prescale = 8 -> three data_valid pulses with P_DATA 0x11, 0x22, 0x33, in order.
REQ-034 RST asserted mid-DATA of frame 0xFF -> all outputs 0 immediately; no pulse; the next frame 0x81 is received correctly.
